// File: rtl/otbn_mont_mul_pipe_pkg.sv
// Shared definitions for the OTBN PQ Montgomery multiplier.
//   mul_mode_e : operation select carried with each transaction
//   DataWidth / LogR / NumLanes : default lane width, radix exponent, lane count
package otbn_pq_pkg;

    localparam int DataWidth = 32;
    localparam int LogR      = 32;
    localparam int NumLanes  = 8;

    typedef enum logic {
        MODE_MONT  = 1'b0,
        MODE_MULLO = 1'b1
    } mul_mode_e;

endpackage

// File: rtl/otbn_mont_mul_pipe_if.sv
// Handshake/data bundle of the Montgomery multiplier.
//   slave  : the multiplier side (accepts operands, produces results)
//   master : the producer/consumer side driving operands and ready_i
// Lane k of op0_i/op1_i/res_o is bits [k*DATA_WIDTH +: DATA_WIDTH].
interface otbn_mont_mul_pipe_if #(
    parameter int DATA_WIDTH = otbn_pq_pkg::DataWidth,
    parameter int LOG_R      = otbn_pq_pkg::LogR,
    parameter int NUM_LANES  = otbn_pq_pkg::NumLanes
);
    logic                            valid_i;
    logic                            ready_o;
    logic                            mode_i;
    logic [NUM_LANES*DATA_WIDTH-1:0] op0_i;
    logic [NUM_LANES*DATA_WIDTH-1:0] op1_i;
    logic [DATA_WIDTH-1:0]           q_i;
    logic [LOG_R-1:0]                q_dash_i;
    logic                            flush_i;
    logic                            valid_o;
    logic                            ready_i;
    logic [NUM_LANES*DATA_WIDTH-1:0] res_o;
    logic                            busy_o;

    modport slave (
        input  valid_i, mode_i, op0_i, op1_i, q_i, q_dash_i, flush_i, ready_i,
        output ready_o, valid_o, res_o, busy_o
    );

    modport master (
        output valid_i, mode_i, op0_i, op1_i, q_i, q_dash_i, flush_i, ready_i,
        input  ready_o, valid_o, res_o, busy_o
    );
endinterface

// File: rtl/otbn_mont_mul_pipe_lane.sv
// One lane of the Montgomery multiplier: three register stages, all
// advancing together on en.
//   S1: p = op0*op1                     (+ mode, q, q_dash)
//   S2: m = (p mod R)*q_dash mod R; u = m*q   (+ p, mode, q)
//   S3: t = (p+u) >> LOG_R, one conditional subtract of q; or p low half
// Ports: clk, rst_n (async low), en, op0, op1, mode, q, q_dash in; res out.
module otbn_mont_mul_lane
    import otbn_pq_pkg::*;
#(
    parameter int DATA_WIDTH = DataWidth,
    parameter int LOG_R      = LogR     // must be >= DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] op0,
    input  logic [DATA_WIDTH-1:0] op1,
    input  mul_mode_e             mode,
    input  logic [DATA_WIDTH-1:0] q,
    input  logic [LOG_R-1:0]      q_dash,
    output logic [DATA_WIDTH-1:0] res
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DW;             // product width
    localparam int UW = LOG_R + DW;         // m*q width
    localparam int SW = DW + LOG_R + 1;     // p+u with carry

    typedef struct packed {
        logic [PW-1:0]    p;
        mul_mode_e        mode;
        logic [DW-1:0]    q;
        logic [LOG_R-1:0] q_dash;
    } s1_t;

    typedef struct packed {
        logic [PW-1:0] p;
        logic [UW-1:0] u;
        mul_mode_e     mode;
        logic [DW-1:0] q;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic [DW-1:0] res_d, res_q;

    // S1
    always_comb begin
        s1_d.p      = {{DW{1'b0}}, op0} * {{DW{1'b0}}, op1};
        s1_d.mode   = mode;
        s1_d.q      = q;
        s1_d.q_dash = q_dash;
    end

    // S2: p is zero-extended so LOG_R may exceed the product width
    logic [SW-1:0]    p_ext;
    logic [LOG_R-1:0] m;
    logic [UW-1:0]    u;

    assign p_ext = {{(SW - PW){1'b0}}, s1_q.p};
    assign m     = p_ext[LOG_R-1:0] * s1_q.q_dash;
    assign u     = {{DW{1'b0}}, m} * {{LOG_R{1'b0}}, s1_q.q};

    always_comb begin
        s2_d.p    = s1_q.p;
        s2_d.u    = u;
        s2_d.mode = s1_q.mode;
        s2_d.q    = s1_q.q;
    end

    // S3: low LOG_R bits of p+u are zero by construction of m
    logic [SW-1:0] s;
    logic [DW:0]   t, t_sub;

    assign s     = {{(SW - PW){1'b0}}, s2_q.p} + {1'b0, s2_q.u};
    assign t     = s[SW-1:LOG_R];
    assign t_sub = t - {1'b0, s2_q.q};

    always_comb begin
        res_d = t[DW-1:0];
        if (s2_q.mode == MODE_MULLO) begin
            res_d = s2_q.p[DW-1:0];
        end else if (t >= {1'b0, s2_q.q}) begin
            res_d = t_sub[DW-1:0];
        end
    end

    logic unused_bits;
    assign unused_bits = ^{p_ext[SW-1:LOG_R], s[LOG_R-1:0], t_sub[DW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
        end else if (en) begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            res_q <= res_d;
        end
    end

    assign res = res_q;

endmodule

// File: rtl/otbn_mont_mul_pipe.sv
// Multi-lane pipelined Montgomery / low-half multiplier for OTBN PQ ops.
// res = op0*op1*2^-LOG_R mod q per lane (MODE_MONT) or (op0*op1) low half
// (MODE_MULLO). Fixed 3-cycle latency, 1 txn/cycle, whole-pipe stall on
// output backpressure, flush drops everything in flight.
// Ports: clk_i, rst_ni (async low) plus the slave side of
// otbn_mont_mul_pipe_if (valid/ready in and out, operands, q, q_dash,
// flush, result, busy).
module otbn_mont_mul_pipe
    import otbn_pq_pkg::*;
#(
    parameter int DATA_WIDTH = DataWidth,
    parameter int LOG_R      = LogR,
    parameter int NUM_LANES  = NumLanes
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    otbn_mont_mul_pipe_if.slave bus
);
    localparam int STAGES = 3;

    logic [STAGES:1] vld_q;
    logic [STAGES:0] vld_pipe;
    logic            stall, accept;

    // The whole pipe freezes while the head result is refused; bubbles are
    // kept in place rather than collapsed.
    assign stall       = vld_q[STAGES] & ~bus.ready_i;
    assign bus.ready_o = ~stall & ~bus.flush_i;
    assign accept      = bus.valid_i & bus.ready_o;
    assign vld_pipe    = {vld_q, accept};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else if (bus.flush_i) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q <= vld_pipe[STAGES-1:0];
        end
    end

    assign bus.valid_o = vld_q[STAGES];
    assign bus.busy_o  = |vld_q;

    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] op0_l, op1_l, res_l;
    mul_mode_e mode;

    assign op0_l     = bus.op0_i;
    assign op1_l     = bus.op1_i;
    assign mode      = mul_mode_e'(bus.mode_i);
    assign bus.res_o = res_l;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        otbn_mont_mul_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .LOG_R      (LOG_R)
        ) u_lane (
            .clk    (clk_i),
            .rst_n  (rst_ni),
            .en     (~stall),
            .op0    (op0_l[k]),
            .op1    (op1_l[k]),
            .mode   (mode),
            .q      (bus.q_i),
            .q_dash (bus.q_dash_i),
            .res    (res_l[k])
        );
    end

endmodule

// File: tb/tb_otbn_mont_mul_pipe.sv
// Directed bench for otbn_mont_mul_pipe: identity, low-half multiply,
// streaming with mixed moduli, backpressure, flush and mid-run reset.
module tb_otbn_mont_mul_pipe;
    localparam int DW = 32;
    localparam int LR = 32;
    localparam int NL = 8;
    localparam int VW = NL * DW;

    localparam logic [DW-1:0] Q1  = 32'd8380417;
    localparam logic [DW-1:0] QD1 = 32'd4236238847;
    localparam logic [DW-1:0] Q2  = 32'd3329;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    otbn_mont_mul_pipe_if #(.DATA_WIDTH(DW), .LOG_R(LR), .NUM_LANES(NL)) bus ();

    otbn_mont_mul_pipe #(.DATA_WIDTH(DW), .LOG_R(LR), .NUM_LANES(NL)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int win_n, win_first, win_last;
    logic [DW-1:0] qd2;
    logic [VW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent reference: reduce a*b mod q, then divide by 2 mod q LR times.
    function automatic logic [DW-1:0] mont_ref(input logic [DW-1:0] a, b, q);
        logic [63:0] x;
        x = (64'(a) * 64'(b)) % 64'(q);
        repeat (LR) x = x[0] ? ((x + 64'(q)) >> 1) : (x >> 1);
        return x[DW-1:0];
    endfunction

    function automatic logic [VW-1:0] model(input logic mode, input logic [VW-1:0] a, b,
                                            input logic [DW-1:0] q);
        logic [VW-1:0] r;
        logic [DW-1:0] la, lb;
        r = '0;
        for (int k = 0; k < NL; k++) begin
            la = a[k*DW +: DW];
            lb = b[k*DW +: DW];
            r[k*DW +: DW] = mode ? la * lb : mont_ref(la, lb, q);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] qdash_of(input logic [DW-1:0] q);
        logic [DW-1:0] x;
        x = q;
        repeat (5) x = x * (32'd2 - q * x);
        return -x;
    endfunction

    function automatic logic [VW-1:0] rnd_vec(input logic [DW-1:0] q);
        logic [VW-1:0] v;
        for (int k = 0; k < NL; k++) v[k*DW +: DW] = $urandom_range(q - 1);
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: results checked in order, accepts modelled as they happen.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_out", VW'(bus.valid_o), '0);
                end else begin
                    chk("result", bus.res_o, exp_q.pop_front());
                    if (win_n == 0) win_first = cyc;
                    win_last = cyc;
                    win_n++;
                end
            end
            if (bus.valid_i && bus.ready_o)
                exp_q.push_back(model(bus.mode_i, bus.op0_i, bus.op1_i, bus.q_i));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic mode, input logic [VW-1:0] a, b,
                        input logic [DW-1:0] q, qd);
        bit acc;
        acc = 1'b0;
        bus.valid_i  = 1'b1;
        bus.mode_i   = mode;
        bus.op0_i    = a;
        bus.op1_i    = b;
        bus.q_i      = q;
        bus.q_dash_i = qd;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.ready_o;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", VW'(bus.ready_o), VW'(1));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        chk(tag, VW'(exp_q.size()), '0);
    endtask

    logic [VW-1:0] a, b, e;
    logic [DW-1:0] q, qd;
    int ident[4] = '{1234567, 0, 8380416, 1};

    initial begin
        bus.valid_i = 0; bus.ready_i = 1; bus.flush_i = 0; bus.mode_i = 0;
        bus.op0_i = '0; bus.op1_i = '0; bus.q_i = '0; bus.q_dash_i = '0;
        win_n = 0; win_first = 0; win_last = 0;
        qd2 = qdash_of(Q2);

        // reset state
        tick(3);
        chk("rst_in_valid", VW'(bus.valid_o), '0);
        chk("rst_in_ready", VW'(bus.ready_o), VW'(1));
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        chk("rst_valid", VW'(bus.valid_o), '0);
        chk("rst_busy",  VW'(bus.busy_o), '0);
        chk("rst_res",   bus.res_o, '0);
        chk("rst_ready", VW'(bus.ready_o), VW'(1));

        // identity: (R mod q) * x * R^-1 = x, and 3-cycle latency
        for (int k = 0; k < NL; k++) begin
            a[k*DW +: DW] = 32'd4193792;
            b[k*DW +: DW] = DW'(ident[k % 4]);
        end
        send(1'b0, a, b, Q1, QD1);
        bus.valid_i = 0;
        @(negedge clk) chk("lat_c1", VW'(bus.valid_o), '0);
        @(negedge clk) chk("lat_c2", VW'(bus.valid_o), '0);
        @(negedge clk) chk("lat_c3", VW'(bus.valid_o), VW'(1));
        chk("ident", bus.res_o, b);
        drain("ident_drain");

        // low-half multiply with hand-computed lanes
        a = {32'hDEADBEEF, 32'h12345678, 32'd7, 32'h80000000,
             32'd12345, 32'hFFFFFFFF, 32'h10000, 32'hFFFF};
        b = {32'd1, 32'h10, 32'd9, 32'd2,
             32'd6789, 32'hFFFFFFFF, 32'h10000, 32'h3};
        e = {32'hDEADBEEF, 32'h23456780, 32'd63, 32'd0,
             32'd83810205, 32'd1, 32'd0, 32'h2FFFD};
        send(1'b1, a, b, Q1, QD1);
        bus.valid_i = 0;
        repeat (3) @(negedge clk);
        chk("mullo_vld", VW'(bus.valid_o), VW'(1));
        chk("mullo", bus.res_o, e);
        drain("mullo_drain");

        // streaming, alternating mode and modulus
        win_n = 0;
        for (int i = 0; i < 20; i++) begin
            q  = ((i / 2) % 2 == 1) ? Q2 : Q1;
            qd = ((i / 2) % 2 == 1) ? qd2 : QD1;
            send(1'(i % 2), rnd_vec(q), rnd_vec(q), q, qd);
        end
        bus.valid_i = 0;
        drain("stream_drain");
        chk("stream_n",   VW'(win_n), VW'(20));
        chk("stream_gap", VW'(win_last - win_first + 1), VW'(20));

        // backpressure with 3 in flight
        win_n = 0;
        for (int i = 0; i < 3; i++) send(1'b0, rnd_vec(Q1), rnd_vec(Q1), Q1, QD1);
        bus.valid_i = 0;
        bus.ready_i = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", VW'(bus.ready_o), '0);
            chk("bp_valid", VW'(bus.valid_o), VW'(1));
            chk("bp_hold",  bus.res_o, exp_q[0]);
        end
        chk("bp_q", VW'(exp_q.size()), VW'(3));
        tick(1);
        bus.ready_i = 1;
        drain("bp_drain");
        chk("bp_n",   VW'(win_n), VW'(3));
        chk("bp_gap", VW'(win_last - win_first + 1), VW'(3));

        // flush with 2 in flight and a competing input
        win_n = 0;
        send(1'b0, rnd_vec(Q1), rnd_vec(Q1), Q1, QD1);
        send(1'b1, rnd_vec(Q1), rnd_vec(Q1), Q1, QD1);
        bus.flush_i = 1;
        bus.op0_i = rnd_vec(Q1);
        @(negedge clk) chk("fl_ready", VW'(bus.ready_o), '0);
        @(posedge clk) #1;
        bus.flush_i = 0;
        bus.valid_i = 0;
        exp_q.delete();
        @(negedge clk);
        chk("fl_valid", VW'(bus.valid_o), '0);
        chk("fl_busy",  VW'(bus.busy_o), '0);
        tick(1);
        send(1'b0, rnd_vec(Q2), rnd_vec(Q2), Q2, qd2);
        bus.valid_i = 0;
        drain("fl_drain");
        chk("fl_n", VW'(win_n), VW'(1));

        // asynchronous reset with a full, stalled pipe
        for (int i = 0; i < 3; i++) send(1'b0, rnd_vec(Q1), rnd_vec(Q1), Q1, QD1);
        bus.valid_i = 0;
        bus.ready_i = 0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", VW'(bus.valid_o), '0);
        chk("arst_res",   bus.res_o, '0);
        chk("arst_busy",  VW'(bus.busy_o), '0);
        exp_q.delete();
        bus.ready_i = 1;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("arst_stale", VW'(bus.valid_o), '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
